// File: rtl/csi_rx_lane_reset_seq.sv
// CSI-2 receive reset sequencer: qualifies MMCM lock, releases the global
// receive reset, then walks the enabled lanes out of reset one at a time.
module csi_rx_lane_reset_seq #(
    parameter int NUM_LANES          = 2,
    parameter int SYNC_STAGES        = 3,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int LANE_STAGGER       = 4,
    parameter int CNT_W              = 8
) (
    input  logic                 byte_clock,
    input  logic                 reset,
    input  logic                 pll_lock,
    input  logic [NUM_LANES-1:0] lane_en,
    input  logic                 clear_err,
    output logic                 reset_out,
    output logic [NUM_LANES-1:0] lane_reset,
    output logic                 ready,
    output logic                 lock_lost,
    output logic [CNT_W-1:0]     lock_loss_cnt
);
    localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int STG_W  = (LANE_STAGGER > 1) ? $clog2(LANE_STAGGER) : 1;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [STAB_W-1:0]      stab_cnt_q, stab_cnt_d;
    logic [STG_W-1:0]       stg_cnt_q, stg_cnt_d;
    logic [NUM_LANES-1:0]   pend_q, pend_d;
    logic                   reset_out_q, reset_out_d;
    logic [NUM_LANES-1:0]   lane_reset_q, lane_reset_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]       lock_loss_cnt_q, lock_loss_cnt_d;

    logic                   lock_s;
    logic                   loss_s;
    logic [NUM_LANES-1:0]   pend_less_s;
    logic [NUM_LANES-1:0]   rel_bit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    assign lock_s = sync_q[SYNC_STAGES-1];
    // Clearing the lowest pending bit picks the next lane in ascending order.
    assign pend_less_s = pend_q & (pend_q - NUM_LANES'(1));
    assign rel_bit_s   = pend_q ^ pend_less_s;

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        sync_d          = {sync_q[SYNC_STAGES-2:0], pll_lock};
        state_d         = state_q;
        stab_cnt_d      = stab_cnt_q;
        stg_cnt_d       = stg_cnt_q;
        pend_d          = pend_q;
        reset_out_d     = reset_out_q;
        lane_reset_d    = lane_reset_q;
        ready_d         = ready_q;
        lock_lost_d     = lock_lost_q;
        lock_loss_cnt_d = lock_loss_cnt_q;
        loss_s          = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                stab_cnt_d   = {STAB_W{1'b0}};
                reset_out_d  = 1'b1;
                lane_reset_d = {NUM_LANES{1'b1}};
                ready_d      = 1'b0;
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d    = ST_WAIT_LOCK;
                    stab_cnt_d = {STAB_W{1'b0}};
                end else if (stab_cnt_q == STAB_W'(LOCK_STABLE_CYCLES - 1)) begin
                    // Lane mask is frozen here for the whole release walk.
                    pend_d      = lane_en;
                    reset_out_d = 1'b0;
                    stg_cnt_d   = {STG_W{1'b0}};
                    if (lane_en == {NUM_LANES{1'b0}}) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    loss_s = 1'b1;
                end else if (stg_cnt_q == STG_W'(LANE_STAGGER - 1)) begin
                    stg_cnt_d    = {STG_W{1'b0}};
                    pend_d       = pend_less_s;
                    lane_reset_d = lane_reset_q & ~rel_bit_s;
                    if (pend_less_s == {NUM_LANES{1'b0}}) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    stg_cnt_d = stg_cnt_q + STG_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    loss_s = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase

        // A counted loss overrides a simultaneous clear_err.
        if (loss_s) begin
            state_d         = ST_WAIT_LOCK;
            stab_cnt_d      = {STAB_W{1'b0}};
            reset_out_d     = 1'b1;
            lane_reset_d    = {NUM_LANES{1'b1}};
            ready_d         = 1'b0;
            lock_lost_d     = 1'b1;
            if (clear_err) begin
                lock_loss_cnt_d = CNT_W'(1);
            end else begin
                lock_loss_cnt_d = sat_inc(lock_loss_cnt_q);
            end
        end else if (clear_err) begin
            lock_lost_d     = 1'b0;
            lock_loss_cnt_d = {CNT_W{1'b0}};
        end else begin
            lock_lost_d     = lock_lost_q;
            lock_loss_cnt_d = lock_loss_cnt_q;
        end
    end

    // State, synchroniser and output registers with synchronous reset.
    always_ff @(posedge byte_clock) begin
        if (reset) begin
            sync_q          <= {SYNC_STAGES{1'b0}};
            state_q         <= ST_WAIT_LOCK;
            stab_cnt_q      <= {STAB_W{1'b0}};
            stg_cnt_q       <= {STG_W{1'b0}};
            pend_q          <= {NUM_LANES{1'b0}};
            reset_out_q     <= 1'b1;
            lane_reset_q    <= {NUM_LANES{1'b1}};
            ready_q         <= 1'b0;
            lock_lost_q     <= 1'b0;
            lock_loss_cnt_q <= {CNT_W{1'b0}};
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            stab_cnt_q      <= stab_cnt_d;
            stg_cnt_q       <= stg_cnt_d;
            pend_q          <= pend_d;
            reset_out_q     <= reset_out_d;
            lane_reset_q    <= lane_reset_d;
            ready_q         <= ready_d;
            lock_lost_q     <= lock_lost_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign reset_out     = reset_out_q;
    assign lane_reset    = lane_reset_q;
    assign ready         = ready_q;
    assign lock_lost     = lock_lost_q;
    assign lock_loss_cnt = lock_loss_cnt_q;
endmodule

// File: tb/tb_csi_rx_lane_reset_seq.sv
// Bench for csi_rx_lane_reset_seq: two configurations driven together, checked
// every cycle against a lock-run-length model plus directed timing checks.
module tb_csi_rx_lane_reset_seq;
    localparam int HSZ = 20000;

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       clear_err;
    logic [1:0] lane_en_a;
    logic [3:0] lane_en_b;

    logic       reset_out_a, ready_a, lock_lost_a;
    logic [1:0] lane_reset_a;
    logic [7:0] cnt_a;
    logic       reset_out_b, ready_b, lock_lost_b;
    logic [3:0] lane_reset_b;
    logic [1:0] cnt_b;

    csi_rx_lane_reset_seq dut_a (
        .byte_clock(clk), .reset(reset), .pll_lock(pll_lock), .lane_en(lane_en_a),
        .clear_err(clear_err), .reset_out(reset_out_a), .lane_reset(lane_reset_a),
        .ready(ready_a), .lock_lost(lock_lost_a), .lock_loss_cnt(cnt_a)
    );

    csi_rx_lane_reset_seq #(
        .NUM_LANES(4), .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(5), .LANE_STAGGER(3), .CNT_W(2)
    ) dut_b (
        .byte_clock(clk), .reset(reset), .pll_lock(pll_lock), .lane_en(lane_en_b),
        .clear_err(clear_err), .reset_out(reset_out_b), .lane_reset(lane_reset_b),
        .ready(ready_b), .lock_lost(lock_lost_b), .lock_loss_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: outputs follow from k = number of consecutive edges with lock_s high.
    typedef struct {
        int k;
        int mask;
        bit lost;
        int cnt;
    } mstate_t;

    bit      pll_hist[HSZ];
    int      edge_cnt = 0;
    int      rst_edge = 0;
    mstate_t ma, mb;

    function automatic bit lock_at(input int n, input int stages);
        if (n - rst_edge > stages && n - stages >= 1) return pll_hist[n - stages];
        return 1'b0;
    endfunction

    function automatic mstate_t m_step(input mstate_t s, input bit rst, input bit ls,
                                       input int en, input bit clr, input int L, input int cmax);
        mstate_t r = s;
        if (rst) begin
            r.k = 0; r.mask = 0; r.lost = 1'b0; r.cnt = 0;
        end else if (!ls) begin
            r.k = 0;
            if (s.k >= L + 1) begin
                r.lost = 1'b1;
                r.cnt  = clr ? 1 : ((s.cnt < cmax) ? s.cnt + 1 : cmax);
            end else if (clr) begin
                r.lost = 1'b0; r.cnt = 0;
            end
        end else begin
            r.k = (s.k < 100000) ? s.k + 1 : s.k;
            if (r.k == L + 1) r.mask = en;
            if (clr) begin
                r.lost = 1'b0; r.cnt = 0;
            end
        end
        return r;
    endfunction

    task automatic m_out(input mstate_t s, input int L, input int S, input int nl,
                         output int ro, output int lr, output int rd);
        int j, e, rc, done;
        ro = (s.k < L + 1) ? 1 : 0;
        j  = s.k - (L + 1);
        e  = 0;
        for (int i = 0; i < nl; i++) e += (s.mask >> i) & 1;
        rc = (ro == 1) ? 0 : ((j / S < e) ? j / S : e);
        lr = (1 << nl) - 1;
        done = 0;
        for (int i = 0; i < nl; i++) begin
            if (((s.mask >> i) & 1) == 1 && done < rc) begin
                lr = lr & ~(1 << i);
                done++;
            end
        end
        rd = (ro == 0 && j >= e * S + 1) ? 1 : 0;
    endtask

    // Advance the model on every active edge using the same sampled inputs.
    always @(posedge clk) begin
        edge_cnt++;
        if (edge_cnt < HSZ) pll_hist[edge_cnt] = pll_lock;
        if (reset) rst_edge = edge_cnt;
        ma = m_step(ma, reset, lock_at(edge_cnt, 3), int'(lane_en_a), clear_err, 64, 255);
        mb = m_step(mb, reset, lock_at(edge_cnt, 2), int'(lane_en_b), clear_err, 5, 3);
    end

    // Compare both DUTs against the model away from the active edge.
    always @(negedge clk) begin
        int ro, lr, rd;
        if (chk_en) begin
            m_out(ma, 64, 4, 2, ro, lr, rd);
            chk("a_reset_out", int'(reset_out_a), ro);
            chk("a_lane_reset", int'(lane_reset_a), lr);
            chk("a_ready", int'(ready_a), rd);
            chk("a_lock_lost", int'(lock_lost_a), int'(ma.lost));
            chk("a_loss_cnt", int'(cnt_a), ma.cnt);
            m_out(mb, 5, 3, 4, ro, lr, rd);
            chk("b_reset_out", int'(reset_out_b), ro);
            chk("b_lane_reset", int'(lane_reset_b), lr);
            chk("b_ready", int'(ready_b), rd);
            chk("b_lock_lost", int'(lock_lost_b), int'(mb.lost));
            chk("b_loss_cnt", int'(cnt_b), mb.cnt);
        end
    end

    initial begin
        int e1, ra, la0, la1, rya, rb, lb1, lb3, ryb, n, cyc;
        reset = 1'b1; pll_lock = 1'b0; clear_err = 1'b0;
        lane_en_a = 2'b11; lane_en_b = 4'b1010;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_reset_out", int'(reset_out_a), 1);
        chk("rst_lane_reset_a", int'(lane_reset_a), 3);
        chk("rst_lane_reset_b", int'(lane_reset_b), 15);
        chk("rst_ready", int'(ready_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);

        // Lock held from the first edge after reset; record release timing.
        reset = 1'b0; pll_lock = 1'b1;
        e1 = edge_cnt + 1;
        ra = -1; la0 = -1; la1 = -1; rya = -1; rb = -1; lb1 = -1; lb3 = -1; ryb = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n = edge_cnt - e1;
            if (ra  < 0 && reset_out_a == 1'b0)     ra  = n;
            if (la0 < 0 && lane_reset_a[0] == 1'b0) la0 = n;
            if (la1 < 0 && lane_reset_a[1] == 1'b0) la1 = n;
            if (rya < 0 && ready_a == 1'b1)         rya = n;
            if (rb  < 0 && reset_out_b == 1'b0)     rb  = n;
            if (lb1 < 0 && lane_reset_b[1] == 1'b0) lb1 = n;
            if (lb3 < 0 && lane_reset_b[3] == 1'b0) lb3 = n;
            if (ryb < 0 && ready_b == 1'b1)         ryb = n;
            if (n == 9)  lane_en_b = 4'b0101;
            if (n == 70) lane_en_a = 2'b01;
        end
        chk("t1_a_reset_fall", ra, 67);
        chk("t1_a_lane0_fall", la0, 71);
        chk("t1_a_lane1_fall", la1, 75);
        chk("t1_a_ready_rise", rya, 76);
        chk("t1_a_lock_lost", int'(lock_lost_a), 0);
        chk("t4_b_reset_fall", rb, 7);
        chk("t4_b_lane1_fall", lb1, 10);
        chk("t4_b_lane3_fall", lb3, 13);
        chk("t4_b_ready_rise", ryb, 14);
        chk("t4_b_lane_mask", int'(lane_reset_b), 4'b0101);

        // Loss from RUN.
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        repeat (6) @(negedge clk);
        chk("t3_reset_out", int'(reset_out_a), 1);
        chk("t3_lane_reset", int'(lane_reset_a), 3);
        chk("t3_ready", int'(ready_a), 0);
        chk("t3_lock_lost", int'(lock_lost_a), 1);
        chk("t3_loss_cnt", int'(cnt_a), 1);
        repeat (90) @(negedge clk);
        chk("t3_ready_again", int'(ready_a), 1);

        // Repeated losses saturate the 2-bit counter.
        for (int r = 0; r < 5; r++) begin
            pll_lock = 1'b1; repeat (20) @(negedge clk);
            pll_lock = 1'b0; repeat (4) @(negedge clk);
        end
        chk("t5_b_saturated", int'(cnt_b), 3);
        pll_lock = 1'b1; repeat (20) @(negedge clk);
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("t5_b_clr_vs_loss_cnt", int'(cnt_b), 1);
        chk("t5_b_clr_vs_loss_lost", int'(lock_lost_b), 1);
        chk("t5_a_cleared_cnt", int'(cnt_a), 0);
        chk("t5_a_cleared_lost", int'(lock_lost_a), 0);

        // Reset in the middle of lane release.
        pll_lock = 1'b1; lane_en_a = 2'b11;
        for (int i = 0; i < 200 && lane_reset_a[0] != 1'b0; i++) @(negedge clk);
        chk("t6_lane0_released", int'(lane_reset_a[0]), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_reset_out", int'(reset_out_a), 1);
        chk("t6_lane_reset", int'(lane_reset_a), 3);
        chk("t6_ready", int'(ready_a), 0);

        // One-cycle drop while still qualifying lock restarts the count.
        repeat (45) @(negedge clk);
        chk("t2_still_in_reset", int'(reset_out_a), 1);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        e1 = edge_cnt + 1;
        ra = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ra < 0 && reset_out_a == 1'b0) ra = edge_cnt - e1;
        end
        chk("t2_a_reset_fall", ra, 67);
        chk("t2_a_loss_cnt", int'(cnt_a), 0);

        // Randomised lock behaviour, lane masks, clears and resets.
        cyc = 0;
        while (cyc < 4000) begin
            int len, r;
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                pll_lock = 1'b1; len = int'($urandom_range(40, 160));
            end else if (r < 8) begin
                pll_lock = 1'b0; len = int'($urandom_range(1, 8));
            end else begin
                pll_lock = 1'b1; len = int'($urandom_range(1, 12));
            end
            lane_en_a = 2'($urandom_range(0, 3));
            lane_en_b = 4'($urandom_range(0, 15));
            for (int c = 0; c < len; c++) begin
                clear_err = ($urandom_range(0, 39) == 0);
                reset     = ($urandom_range(0, 699) == 0);
                @(negedge clk);
                cyc++;
            end
        end
        reset = 1'b0; clear_err = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
